// File: rtl/iob_eth_rx_ctrl.sv
// MII receive-path controller: preamble/SFD detection, nibble-to-byte assembly, CRC sequencing,
// single-frame buffer handoff with drop counting. Optional destination filter: IOB_ETH_RX_MAC_FILTER_EN.
module iob_eth_rx_ctrl #(
   parameter int unsigned BUF_ADDR_W  = 11,
   parameter int unsigned MIN_BYTES   = 64,
   parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
   input  logic                  RX_CLK,
   input  logic                  reset,
   input  logic                  RX_DV,
   input  logic [3:0]            RX_DATA,
   input  logic [47:0]           mac_addr,
   output logic                  buf_wr_en,
   output logic [BUF_ADDR_W-1:0] buf_wr_addr,
   output logic [7:0]            buf_wr_data,
   output logic                  crc_start,
   output logic                  crc_en,
   output logic [7:0]            crc_data,
   input  logic [31:0]           crc_value,
   output logic                  frame_ready,
   output logic [BUF_ADDR_W:0]   frame_len,
   output logic                  frame_crc_err,
   input  logic                  frame_ack,
   output logic [15:0]           drop_cnt
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PRE   = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   localparam logic [2:0] DROP  = 3'd5;

   localparam logic [BUF_ADDR_W:0] CAP     = {1'b1, {BUF_ADDR_W{1'b0}}};
   localparam logic [BUF_ADDR_W:0] MIN_CNT = (BUF_ADDR_W+1)'(MIN_BYTES);
   localparam logic [BUF_ADDR_W:0] FCS_LEN = (BUF_ADDR_W+1)'(4);

   logic [2:0]            state_q, state_d;
   logic [3:0]            nib_q, nib_d;
   logic                  half_q, half_d;
   logic [BUF_ADDR_W:0]   byte_cnt_q, byte_cnt_d;
   logic                  rx_dv_q, rx_dv_d;
   logic                  wr_en_q, wr_en_d;
   logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  crc_start_q, crc_start_d;
   logic                  crc_en_q, crc_en_d;
   logic [7:0]            crc_data_q, crc_data_d;
   logic                  ready_q, ready_d;
   logic [BUF_ADDR_W:0]   len_q, len_d;
   logic                  err_q, err_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic                  drop_inc;
   logic [7:0]            rx_byte;

`ifdef IOB_ETH_RX_MAC_FILTER_EN
   logic [47:0]           dst_q, dst_d;
`else
   logic                  unused_mac;
   assign unused_mac = ^mac_addr;
`endif

   assign rx_byte = {RX_DATA, nib_q};

   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      half_d      = half_q;
      byte_cnt_d  = byte_cnt_q;
      rx_dv_d     = RX_DV;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      crc_start_d = 1'b0;
      crc_en_d    = 1'b0;
      crc_data_d  = crc_data_q;
      ready_d     = ready_q;
      len_d       = len_q;
      err_d       = err_q;
      drop_inc    = 1'b0;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
      dst_d       = dst_q;
`endif
      case (state_q)
         IDLE: begin
            if (RX_DV) begin
               if (RX_DATA == 4'h5) begin
                  state_d = PRE;
               end else begin
                  state_d  = DROP;
                  drop_inc = 1'b1;
               end
            end
         end
         PRE: begin
            if (!RX_DV) begin
               state_d = IDLE;
            end else if (RX_DATA == 4'hD) begin
               state_d     = DATA;
               crc_start_d = 1'b1;
               byte_cnt_d  = '0;
               half_d      = 1'b0;
            end else if (RX_DATA != 4'h5) begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end
         end
         DATA: begin
            if (RX_DV) begin
               if (byte_cnt_q == CAP) begin
                  state_d  = DROP;
                  drop_inc = 1'b1;
               end else if (!half_q) begin
                  nib_d  = RX_DATA;
                  half_d = 1'b1;
               end else begin
                  half_d     = 1'b0;
                  wr_en_d    = 1'b1;
                  crc_en_d   = 1'b1;
                  wr_addr_d  = byte_cnt_q[BUF_ADDR_W-1:0];
                  wr_data_d  = rx_byte;
                  crc_data_d = rx_byte;
                  byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
                  // Byte 5 is written before the destination verdict is known.
                  dst_d = {dst_q[39:0], rx_byte};
                  if (byte_cnt_q == (BUF_ADDR_W+1)'(5) && dst_d != mac_addr && dst_d != '1) begin
                     state_d  = DROP;
                     drop_inc = 1'b1;
                  end
`endif
               end
            end else if (byte_cnt_q < MIN_CNT || half_q) begin
               state_d  = IDLE;
               drop_inc = 1'b1;
            end else begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            ready_d = 1'b1;
            len_d   = byte_cnt_q - FCS_LEN;
            err_d   = (crc_value != CRC_RESIDUE);
            state_d = HOLD;
            if (RX_DV && !rx_dv_q) drop_inc = 1'b1;
         end
         HOLD: begin
            if (RX_DV && !rx_dv_q) drop_inc = 1'b1;
            if (frame_ack) begin
               ready_d = 1'b0;
               state_d = RX_DV ? DROP : IDLE;
            end
         end
         DROP: begin
            if (!RX_DV) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      drop_cnt_d = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge RX_CLK or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         nib_q       <= '0;
         half_q      <= 1'b0;
         byte_cnt_q  <= '0;
         rx_dv_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         crc_start_q <= 1'b0;
         crc_en_q    <= 1'b0;
         crc_data_q  <= '0;
         ready_q     <= 1'b0;
         len_q       <= '0;
         err_q       <= 1'b0;
         drop_cnt_q  <= '0;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
         dst_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         nib_q       <= nib_d;
         half_q      <= half_d;
         byte_cnt_q  <= byte_cnt_d;
         rx_dv_q     <= rx_dv_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         crc_start_q <= crc_start_d;
         crc_en_q    <= crc_en_d;
         crc_data_q  <= crc_data_d;
         ready_q     <= ready_d;
         len_q       <= len_d;
         err_q       <= err_d;
         drop_cnt_q  <= drop_cnt_d;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
         dst_q       <= dst_d;
`endif
      end
   end

   assign buf_wr_en     = wr_en_q;
   assign buf_wr_addr   = wr_addr_q;
   assign buf_wr_data   = wr_data_q;
   assign crc_start     = crc_start_q;
   assign crc_en        = crc_en_q;
   assign crc_data      = crc_data_q;
   assign frame_ready   = ready_q;
   assign frame_len     = len_q;
   assign frame_crc_err = err_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_ctrl.sv
// Scoreboard bench for iob_eth_rx_ctrl: randomized MII frames, frame-level reference model,
// and a behavioural CRC-32 engine standing in for iob_eth_crc.
module tb_iob_eth_rx_ctrl;

   localparam int AW   = 6;
   localparam int CAP  = 64;
   localparam int MINB = 64;
   localparam logic [47:0] MAC = 48'h02AABBCCDDEE;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic          RX_CLK = 1'b0;
   logic          reset;
   logic          RX_DV;
   logic [3:0]    RX_DATA;
   logic          buf_wr_en;
   logic [AW-1:0] buf_wr_addr;
   logic [7:0]    buf_wr_data;
   logic          crc_start;
   logic          crc_en;
   logic [7:0]    crc_data;
   logic [31:0]   crc_value;
   logic          frame_ready;
   logic [AW:0]   frame_len;
   logic          frame_crc_err;
   logic          frame_ack;
   logic [15:0]   drop_cnt;

   int checks = 0;
   int errors = 0;
   int model_drops = 0;
   int exp_addr_q[$];
   logic [7:0] exp_data_q[$];
   int exp_len_q[$];
   bit exp_err_q[$];

   iob_eth_rx_ctrl #(.BUF_ADDR_W(AW), .MIN_BYTES(MINB), .CRC_RESIDUE(32'hC704DD7B)) dut (
      .RX_CLK(RX_CLK), .reset(reset), .RX_DV(RX_DV), .RX_DATA(RX_DATA), .mac_addr(MAC),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .crc_start(crc_start), .crc_en(crc_en), .crc_data(crc_data), .crc_value(crc_value),
      .frame_ready(frame_ready), .frame_len(frame_len), .frame_crc_err(frame_crc_err),
      .frame_ack(frame_ack), .drop_cnt(drop_cnt)
   );

   always #5 RX_CLK = ~RX_CLK;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Reflected CRC-32 register; the engine presents it bit-reversed, giving residue C704DD7B.
   logic [31:0] crc_r;
   always_ff @(posedge RX_CLK or posedge reset) begin
      if (reset) crc_r <= '1;
      else if (crc_start) crc_r <= '1;
      else if (crc_en) crc_r <= crc_upd(crc_r, crc_data);
   end
   always_comb begin
      crc_value = '0;
      for (int i = 0; i < 32; i++) crc_value[i] = crc_r[31-i];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit filt_reject(input logic [47:0] dst);
      return FILT && (dst != MAC) && (dst != '1);
   endfunction

   function automatic bq_t make_frame(input int n, input bit fcs, input bit flip, input int sel);
      bq_t f;
      logic [47:0] dst;
      logic [31:0] c;
      int s, nb, idx;
      s   = (sel < 0) ? int'($urandom_range(0, 2)) : sel;
      dst = (s == 0) ? MAC : (s == 1) ? 48'hFFFFFFFFFFFF : (MAC ^ 48'h1);
      nb  = fcs ? n - 4 : n;
      for (int i = 0; i < nb; i++) f.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
      if (fcs) begin
         c = '1;
         foreach (f[i]) c = crc_upd(c, f[i]);
         c = ~c;
         for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
      end
      if (flip) begin
         idx    = $urandom_range(6, nb - 1);
         f[idx] = f[idx] ^ (8'h1 << $urandom_range(0, 7));
      end
      return f;
   endfunction

   task automatic drive_nib(input logic [3:0] n, input bit ack);
      RX_DV     = 1'b1;
      RX_DATA   = n;
      frame_ack = ack;
      @(negedge RX_CLK);
      frame_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      RX_DV   = 1'b0;
      RX_DATA = 4'h0;
      repeat (n) @(negedge RX_CLK);
   endtask

   // Frame-level model: predicts buffer writes, the handed-over frame, and the drop count.
   task automatic run_frame(input bq_t d, input int npre, input logic [3:0] sfd, input bit odd,
                            input int ack_at, input bit in_hold, input bit flipped, output bit acc);
      int n, nw, idx;
      bit drop;
      logic [47:0] dst;
      n = d.size(); nw = 0; acc = 1'b0; drop = 1'b0; dst = '0;
      if (in_hold) drop = 1'b1;
      else if (npre == 0 && sfd != 4'h5) drop = 1'b1;
      else if (sfd == 4'h5) drop = 1'b0;
      else if (sfd != 4'hD) drop = 1'b1;
      else begin
         if (n >= 6) for (int i = 0; i < 6; i++) dst = {dst[39:0], d[i]};
         if (n >= 6 && filt_reject(dst)) begin nw = 6; drop = 1'b1; end
         else if (n > CAP || (n == CAP && odd)) begin nw = CAP; drop = 1'b1; end
         else if (odd || n < MINB) begin nw = n; drop = 1'b1; end
         else begin nw = n; acc = 1'b1; end
      end
      for (int i = 0; i < nw; i++) begin exp_addr_q.push_back(i); exp_data_q.push_back(d[i]); end
      if (acc) begin exp_len_q.push_back(n - 4); exp_err_q.push_back(flipped); end
      if (drop) model_drops++;
      idx = 0;
      for (int i = 0; i < npre; i++) begin drive_nib(4'h5, idx == ack_at); idx++; end
      drive_nib(sfd, idx == ack_at); idx++;
      for (int i = 0; i < n; i++) begin
         drive_nib(d[i][3:0], idx == ack_at); idx++;
         drive_nib(d[i][7:4], idx == ack_at); idx++;
      end
      if (odd) drive_nib(4'($urandom), idx == ack_at);
      idle(16);
      chk("drop_cnt", drop_cnt, model_drops);
   endtask

   task automatic ack_frame();
      int k;
      k = 0;
      while (!frame_ready && k < 20) begin @(negedge RX_CLK); k++; end
      if (!frame_ready) begin
         checks++; errors++;
         $display("FAIL frame_ready_timeout actual=0 required=1 within 20 cycles");
      end else begin
         frame_ack = 1'b1;
         @(negedge RX_CLK);
         frame_ack = 1'b0;
         chk("frame_ready_after_ack", frame_ready, 0);
      end
      idle(2);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_buf_wr_en"}, buf_wr_en, 0);
      chk({tag, "_buf_wr_addr"}, buf_wr_addr, 0);
      chk({tag, "_buf_wr_data"}, buf_wr_data, 0);
      chk({tag, "_crc_start"}, crc_start, 0);
      chk({tag, "_crc_en"}, crc_en, 0);
      chk({tag, "_crc_data"}, crc_data, 0);
      chk({tag, "_frame_ready"}, frame_ready, 0);
      chk({tag, "_frame_len"}, frame_len, 0);
      chk({tag, "_frame_crc_err"}, frame_crc_err, 0);
      chk({tag, "_drop_cnt"}, drop_cnt, 0);
   endtask

   initial begin : monitor
      bit ready_prev, seen_start, herr;
      int hlen, ea;
      logic [7:0] ed;
      ready_prev = 1'b0; seen_start = 1'b0; hlen = 0; herr = 1'b0;
      forever begin
         @(negedge RX_CLK);
         if (reset) begin
            ready_prev = 1'b0;
            seen_start = 1'b0;
         end else begin
            if (crc_start) seen_start = 1'b1;
            if (buf_wr_en || crc_en) begin
               chk("crc_en_vs_wr_en", crc_en, buf_wr_en);
               chk("crc_data_vs_wr_data", crc_data, buf_wr_data);
               if (exp_addr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write actual addr=%0d data=%h required=no write", buf_wr_addr, buf_wr_data);
               end else begin
                  ea = exp_addr_q.pop_front();
                  ed = exp_data_q.pop_front();
                  chk("wr_addr", buf_wr_addr, ea);
                  chk("wr_data", buf_wr_data, ed);
                  if (ea == 0) begin
                     chk("crc_start_before_first_byte", seen_start, 1);
                     seen_start = 1'b0;
                  end
               end
            end
            if (frame_ready && !ready_prev) begin
               if (exp_len_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_frame actual len=%0d required=no frame", frame_len);
               end else begin
                  hlen = exp_len_q.pop_front();
                  herr = exp_err_q.pop_front();
                  chk("frame_len", frame_len, hlen);
                  chk("frame_crc_err", frame_crc_err, herr);
               end
            end else if (frame_ready) begin
               chk("frame_len_held", frame_len, hlen);
               chk("frame_crc_err_held", frame_crc_err, herr);
            end
            ready_prev = frame_ready;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bq_t f, g;
      bit acc;
      int k, n, npre, ack_at;
      logic [3:0] s;
      reset = 1'b1; RX_DV = 1'b0; RX_DATA = 4'h0; frame_ack = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge RX_CLK);
      reset = 1'b0;
      idle(3);

      f = make_frame(64, 1'b1, 1'b0, 0);
      run_frame(f, 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      if (acc) ack_frame();
      g = f;
      g[20] = g[20] ^ 8'h04;
      run_frame(g, 7, 4'hD, 1'b0, -1, 1'b0, 1'b1, acc);
      if (acc) ack_frame();
      run_frame(make_frame(40, 1'b0, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      chk("runt_no_ready", frame_ready, 0);

      // Second frame arrives while the first is held; ack lands mid-frame, then on the rising nibble.
      run_frame(make_frame(64, 1'b1, 1'b0, 1), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(64, 1'b1, 1'b0, 0), 7, 4'hD, 1'b0, 40, 1'b1, 1'b0, acc);
      chk("hold_released", frame_ready, 0);
      run_frame(make_frame(64, 1'b1, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(64, 1'b1, 1'b0, 0), 7, 4'hD, 1'b0, 0, 1'b1, 1'b0, acc);
      chk("hold_released_simul", frame_ready, 0);

      run_frame(make_frame(100, 1'b0, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(63, 1'b0, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(64, 1'b1, 1'b0, 0), 7, 4'hD, 1'b1, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(65, 1'b0, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(8, 1'b0, 1'b0, 0), 5, 4'h3, 1'b0, -1, 1'b0, 1'b0, acc);
      f = {};
      run_frame(f, 3, 4'h5, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(f, 0, 4'hA, 1'b0, -1, 1'b0, 1'b0, acc);
      run_frame(make_frame(64, 1'b1, 1'b0, 2), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      if (acc) ack_frame();

      // Asynchronous reset once byte 29 has been written.
      f = make_frame(64, 1'b1, 1'b0, 0);
      for (int i = 0; i < 30; i++) begin exp_addr_q.push_back(i); exp_data_q.push_back(f[i]); end
      for (int i = 0; i < 7; i++) drive_nib(4'h5, 1'b0);
      drive_nib(4'hD, 1'b0);
      for (int i = 0; i < 30; i++) begin drive_nib(f[i][3:0], 1'b0); drive_nib(f[i][7:4], 1'b0); end
      #1 reset = 1'b1;
      #1 check_all_zero("midframe_reset");
      RX_DV = 1'b0;
      model_drops = 0;
      @(negedge RX_CLK);
      reset = 1'b0;
      idle(4);
      run_frame(make_frame(64, 1'b1, 1'b0, 0), 7, 4'hD, 1'b0, -1, 1'b0, 1'b0, acc);
      if (acc) ack_frame();

      for (int it = 0; it < 25; it++) begin
         k      = $urandom_range(0, 7);
         npre   = $urandom_range(1, 15);
         ack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
         case (k)
            0, 1: run_frame(make_frame(64, 1'b1, k == 1, -1), npre, 4'hD, 1'b0, ack_at, 1'b0, k == 1, acc);
            2: begin
               n = $urandom_range(1, 63);
               run_frame(make_frame(n, 1'b0, 1'b0, -1), npre, 4'hD, 1'b0, ack_at, 1'b0, 1'b0, acc);
            end
            3: begin
               n = $urandom_range(65, 100);
               run_frame(make_frame(n, 1'b0, 1'b0, -1), npre, 4'hD, 1'b0, ack_at, 1'b0, 1'b0, acc);
            end
            4: run_frame(make_frame(64, 1'b1, 1'b0, -1), npre, 4'hD, 1'b1, ack_at, 1'b0, 1'b0, acc);
            5: begin
               s = 4'($urandom);
               while (s == 4'h5 || s == 4'hD) s = 4'($urandom);
               run_frame(make_frame(8, 1'b0, 1'b0, -1), npre, s, 1'b0, ack_at, 1'b0, 1'b0, acc);
            end
            6: begin
               f = {};
               run_frame(f, npre, 4'h5, 1'b0, ack_at, 1'b0, 1'b0, acc);
            end
            default: begin
               f = {};
               s = 4'($urandom);
               while (s == 4'h5) s = 4'($urandom);
               run_frame(f, 0, s, 1'b0, ack_at, 1'b0, 1'b0, acc);
            end
         endcase
         if (acc) ack_frame();
         else chk("no_frame_ready", frame_ready, 0);
      end

      idle(4);
      chk("pending_writes", exp_addr_q.size(), 0);
      chk("pending_frames", exp_len_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
